// File: rtl/boxlambda_reset_ctrl.sv
// Reset conditioner: debounces the board reset, waits for PLL lock, stretches every release,
// and produces synchronously released system and non-debug-module resets plus a cause code.
module boxlambda_reset_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 16
) (
  input  logic       ext_clk_100,
  input  logic       ext_rst_n,
  input  logic       pll_locked,
  input  logic       ndm_reset_req,
  output logic       sys_rst_n,
  output logic       ndm_rst_n,
  output logic [1:0] reset_cause,
  output logic       pll_locked_led
);

  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                   : HOLD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] NdmLast  = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [1:0] CauseExt  = 2'b01;
  localparam logic [1:0] CauseLock = 2'b10;
  localparam logic [1:0] CauseNdm  = 2'b11;

  typedef enum logic [2:0] {
    StDebounce,
    StWaitLock,
    StHold,
    StRun,
    StNdmHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            sys_rst_n_q, ndm_rst_n_q;

  logic rst_meta_q, rst_sync_q;
  logic lock_meta_q, lock_sync_q;

  // Both synchronizers read as 0 until two clean edges have passed after reset.
  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      rst_meta_q  <= 1'b0;
      rst_sync_q  <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      rst_meta_q  <= ext_rst_n;
      rst_sync_q  <= rst_meta_q;
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      StDebounce: begin
        if (rst_sync_q) begin
          if (cnt_q >= DebLast) begin
            cnt_d   = '0;
            state_d = lock_sync_q ? StHold : StWaitLock;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StWaitLock: begin
        cnt_d = '0;
        if (lock_sync_q) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!lock_sync_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q >= HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        cnt_d = '0;
        // Lock loss wins over a simultaneous debug reset request.
        if (!lock_sync_q) begin
          state_d = StWaitLock;
          cause_d = CauseLock;
        end else if (ndm_reset_req) begin
          state_d = StNdmHold;
          cause_d = CauseNdm;
        end
      end
      StNdmHold: begin
        if (!lock_sync_q) begin
          state_d = StWaitLock;
          cause_d = CauseLock;
          cnt_d   = '0;
        end else if (ndm_reset_req) begin
          cnt_d = '0;
        end else if (cnt_q >= NdmLast) begin
          // Terminal count plus one more edge gives the H+1 edge stretch after the request drops.
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StDebounce;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q     <= StDebounce;
      cnt_q       <= '0;
      cause_q     <= CauseExt;
      sys_rst_n_q <= 1'b0;
      ndm_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      sys_rst_n_q <= (state_d == StRun) || (state_d == StNdmHold);
      ndm_rst_n_q <= (state_d == StRun);
    end
  end

  assign sys_rst_n      = sys_rst_n_q;
  assign ndm_rst_n      = ndm_rst_n_q;
  assign reset_cause    = cause_q;
  assign pll_locked_led = lock_sync_q;

endmodule
